// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer between the audio sample stream and the FFT core.
// Two FRAME_LEN banks: the writer fills one while the reader streams the other with sop/eop framing.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 128,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16
) (
    input  logic              clock_50,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              fft_ready,
    output logic              fft_valid,
    output logic              fft_sop,
    output logic              fft_eop,
    output logic [DATA_W-1:0] data_out_real,
    output logic [DATA_W-1:0] data_out_imag,
    output logic              overflow,
    output logic [7:0]        frame_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];
    logic [DATA_W-1:0] rd_data_q;

    state_t            state_q, state_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              overflow_q, overflow_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic              wr_en;
    logic              set_full;
    logic              clr_full;
    logic              handshake;
    logic              last_beat;
    logic [ADDR_W-1:0] rd_ram_addr;

    // Write side decides on the registered bank_full, so a bank freed this cycle is only writable next cycle.
    always_comb begin
        wr_en      = sample_valid & ~bank_full_q[wr_bank_q];
        set_full   = 1'b0;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        overflow_d = overflow_q;
        if (sample_valid) begin
            if (bank_full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else if (wr_addr_q == LAST_ADDR) begin
                set_full  = 1'b1;
                wr_bank_d = ~wr_bank_q;
                wr_addr_d = '0;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_ONE;
            end
        end
    end

    // Set and clear always target different banks, so both can apply together.
    always_comb begin
        bank_full_d = bank_full_q;
        if (set_full) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (clr_full) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    assign fft_valid = (state_q == STREAM);
    assign handshake = fft_valid & fft_ready;
    assign last_beat = (rd_addr_q == LAST_ADDR);

    always_comb begin
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        rd_addr_d     = rd_addr_q;
        frame_count_d = frame_count_q;
        clr_full      = 1'b0;
        rd_ram_addr   = rd_addr_q;
        case (state_q)
            IDLE: begin
                rd_ram_addr = '0;
                if (bank_full_q[rd_bank_q]) begin
                    state_d = PREFETCH;
                end
            end
            PREFETCH: begin
                rd_ram_addr = '0;
                state_d     = STREAM;
            end
            STREAM: begin
                // Without a handshake the current word is re-read, keeping the beat stable.
                if (handshake) begin
                    if (last_beat) begin
                        clr_full      = 1'b1;
                        rd_bank_d     = ~rd_bank_q;
                        rd_addr_d     = '0;
                        frame_count_d = frame_count_q + 8'd1;
                        state_d       = IDLE;
                    end else begin
                        rd_addr_d   = rd_addr_q + ADDR_ONE;
                        rd_ram_addr = rd_addr_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_addr_q}] <= sample_in;
        end
        rd_data_q <= mem[{rd_bank_q, rd_ram_addr}];
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bank_full_q   <= '0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            overflow_q    <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_addr_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bank_full_q   <= bank_full_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            overflow_q    <= overflow_d;
            rd_bank_q     <= rd_bank_d;
            rd_addr_q     <= rd_addr_d;
            frame_count_q <= frame_count_d;
        end
    end

    // RAM output register has no reset, so data is gated to zero outside STREAM.
    assign data_out_real = fft_valid ? rd_data_q : '0;
    assign data_out_imag = '0;
    assign fft_sop       = fft_valid & (rd_addr_q == '0);
    assign fft_eop       = fft_valid & last_beat;
    assign overflow      = overflow_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: scenario table plus hand sequences; a negedge model
// tracks bank occupancy and queues expected beats as samples are accepted.
module tb_fft_frame_feeder;

    localparam int FL = 128;

    logic        clock_50     = 1'b0;
    logic        reset_n      = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in    = '0;
    logic        fft_ready    = 1'b0;
    logic        fft_valid;
    logic        fft_sop;
    logic        fft_eop;
    logic [15:0] data_out_real;
    logic [15:0] data_out_imag;
    logic        overflow;
    logic [7:0]  frame_count;

    fft_frame_feeder #(.FRAME_LEN(128), .ADDR_W(7), .DATA_W(16)) dut (
        .clock_50      (clock_50),
        .reset_n       (reset_n),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .fft_ready     (fft_ready),
        .fft_valid     (fft_valid),
        .fft_sop       (fft_sop),
        .fft_eop       (fft_eop),
        .data_out_real (data_out_real),
        .data_out_imag (data_out_imag),
        .overflow      (overflow),
        .frame_count   (frame_count)
    );

    always #5 clock_50 = ~clock_50;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        int   start;
        int   count;
        int   gap;
        int   rdy;
        logic ovf;
        int   frames;
    } vec_t;

    beat_t       exp_q[$];
    logic [1:0]  m_full    = '0;
    logic        m_wr_bank = 1'b0;
    logic        m_rd_bank = 1'b0;
    int          m_wr_addr = 0;
    logic        stall     = 1'b0;
    logic [15:0] held_data = '0;
    logic        held_sop  = 1'b0;
    logic        held_eop  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock_50) begin
        #1;
        case (rdy_mode)
            0:       fft_ready = 1'b1;
            1:       fft_ready = 1'($urandom_range(0, 1));
            default: fft_ready = 1'b0;
        endcase
    end

    // Reference model: inputs and outputs are stable at the falling edge and
    // describe what the next rising edge will register.
    always @(negedge clock_50) begin
        if (!reset_n) begin
            exp_q.delete();
            m_full    = '0;
            m_wr_bank = 1'b0;
            m_rd_bank = 1'b0;
            m_wr_addr = 0;
            stall     = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_hold", {fft_valid, data_out_real, fft_sop, fft_eop},
                    {1'b1, held_data, held_sop, held_eop});
            end
            if (sample_valid && !m_full[m_wr_bank]) begin
                exp_q.push_back('{data: sample_in, sop: (m_wr_addr == 0), eop: (m_wr_addr == FL - 1)});
                if (m_wr_addr == FL - 1) begin
                    m_full[m_wr_bank] = 1'b1;
                    m_wr_bank         = ~m_wr_bank;
                    m_wr_addr         = 0;
                end else begin
                    m_wr_addr++;
                end
            end
            if (fft_valid && fft_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {48'h0, data_out_real}, 64'hDEAD_0000);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {data_out_imag, data_out_real, fft_sop, fft_eop},
                        {16'h0, e.data, e.sop, e.eop});
                    if (fft_eop) begin
                        m_full[m_rd_bank] = 1'b0;
                        m_rd_bank         = ~m_rd_bank;
                    end
                end
            end
            stall     = fft_valid && !fft_ready;
            held_data = data_out_real;
            held_sop  = fft_sop;
            held_eop  = fft_eop;
        end
    end

    task automatic do_reset();
        @(posedge clock_50); #1;
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        @(posedge clock_50); #1;
        chk("reset_outputs",
            {fft_valid, fft_sop, fft_eop, data_out_real, data_out_imag, overflow, frame_count},
            64'h0);
        @(posedge clock_50); #1;
        reset_n = 1'b1;
    endtask

    task automatic drive_samples(input int start, input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            @(posedge clock_50); #1;
            sample_valid = 1'b1;
            sample_in    = 16'(start + i);
            for (int g = 1; g < gap; g++) begin
                @(posedge clock_50); #1;
                sample_valid = 1'b0;
            end
        end
        @(posedge clock_50); #1;
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fft_valid) && n < budget) begin
            @(posedge clock_50); #1;
            n++;
        end
        chk(name, 64'(n < budget), 64'h1);
        repeat (2) @(posedge clock_50);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   n_valid;
        logic hit;

        vecs[0] = '{start: 0,     count: 256, gap: 2, rdy: 0, ovf: 1'b0, frames: 2};
        vecs[1] = '{start: 32700, count: 256, gap: 4, rdy: 1, ovf: 1'b0, frames: 2};
        vecs[2] = '{start: 0,     count: 300, gap: 1, rdy: 2, ovf: 1'b1, frames: 2};

        // Single frame: latency from last sample and 128 back-to-back beats.
        do_reset();
        rdy_mode = 0;
        drive_samples(0, FL - 1, 4);
        @(posedge clock_50); #1;
        sample_valid = 1'b1;
        sample_in    = 16'(FL - 1);
        @(posedge clock_50); #1;
        sample_valid = 1'b0;
        chk("t1_valid_T1", 64'(fft_valid), 64'h0);
        @(posedge clock_50); #1;
        chk("t1_valid_T2", 64'(fft_valid), 64'h0);
        @(posedge clock_50); #1;
        chk("t1_first_beat", {fft_valid, fft_sop, data_out_real}, {1'b1, 1'b1, 16'h0});
        n_valid = 0;
        for (int i = 0; i < FL; i++) begin
            if (fft_valid) n_valid++;
            @(posedge clock_50); #1;
        end
        chk("t1_beat_run", 64'(n_valid), 64'(FL));
        chk("t1_valid_after", 64'(fft_valid), 64'h0);
        chk("t1_frame_count", 64'(frame_count), 64'h1);
        chk("t1_overflow", 64'(overflow), 64'h0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            rdy_mode = vecs[v].rdy;
            drive_samples(vecs[v].start, vecs[v].count, vecs[v].gap);
            if (vecs[v].rdy == 2) begin
                chk("vec_stalled_valid", 64'(fft_valid), 64'h1);
                rdy_mode = 0;
            end
            drain("vec_drain", 4000);
            chk("vec_overflow", 64'(overflow), 64'(vecs[v].ovf));
            chk("vec_frame_count", 64'(frame_count), 64'(vecs[v].frames));
        end

        // Reset mid-frame: only the frame written after reset may appear.
        do_reset();
        rdy_mode = 0;
        drive_samples(500, 64, 1);
        do_reset();
        drive_samples(1000, FL, 1);
        drain("t5_drain", 1000);
        chk("t5_frame_count", 64'(frame_count), 64'h1);
        chk("t5_overflow", 64'(overflow), 64'h0);

        // Sample in the eop-handshake cycle aimed at the bank being freed.
        do_reset();
        rdy_mode = 2;
        drive_samples(0, 2 * FL, 1);
        chk("t6_no_overflow_yet", 64'(overflow), 64'h0);
        chk("t6_stalled_valid", 64'(fft_valid), 64'h1);
        rdy_mode = 0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clock_50); #1;
            if (fft_valid && fft_ready && fft_eop) begin
                hit          = 1'b1;
                sample_valid = 1'b1;
                sample_in    = 16'h7777;
                @(posedge clock_50); #1;
                sample_valid = 1'b0;
            end
        end
        chk("t6_eop_seen", 64'(hit), 64'h1);
        chk("t6_overflow", 64'(overflow), 64'h1);
        drive_samples(16'h0100, FL, 2);
        drain("t6_drain", 2000);
        chk("t6_frame_count", 64'(frame_count), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
